// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between core and host.
// Owner/state encodings are used by dmem_arbiter and its burst counter.
package dmem_arb_pkg;

  localparam int DEF_AW        = 16;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CORE       = 2'd1,
    ST_HOST_BURST = 2'd2
  } state_e;

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_burst_cnt.sv
// Saturating count of consecutive locked host grants; clear wins over increment,
// and clear+increment together loads 1 (first grant of a new burst).
module dmem_arb_burst_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CW        = burst_cnt_width(MAX_BURST)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX_BURST);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CW'(1) : '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: core vs host, host burst locking with a bounded
// burst, one-cycle read return routing. DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          core_gnt,
  output logic          host_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e state_q, state_d;
  owner_e rd_owner_q, rd_owner_d;
  logic   cnt_clr, cnt_inc, cnt_at_max;
  logic   burst_hold;

`ifdef DMEM_ARB_RR_EN
  logic core_first_q, core_first_d;
`endif

  dmem_arb_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .at_max_o (cnt_at_max)
  );

  assign burst_hold = (state_q == ST_HOST_BURST) && host_req && host_lock;

  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    state_d  = state_q;
    cnt_clr  = 1'b1;
    cnt_inc  = 1'b0;
`ifdef DMEM_ARB_RR_EN
    core_first_d = core_first_q;
`endif
    if (burst_hold) begin
      // Core gets exactly one slot once the burst limit is reached.
      state_d = ST_HOST_BURST;
      if (cnt_at_max && core_req) begin
        core_gnt = 1'b1;
      end else begin
        host_gnt = 1'b1;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b1;
      end
    end else begin
      if (core_req && host_req) begin
`ifdef DMEM_ARB_RR_EN
        core_gnt = core_first_q;
        host_gnt = !core_first_q;
`else
        core_gnt = 1'b1;
`endif
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
      cnt_inc = host_gnt && host_lock;
      if (core_gnt) begin
        state_d = ST_CORE;
      end else if (host_gnt && host_lock) begin
        state_d = ST_HOST_BURST;
      end else begin
        state_d = ST_IDLE;
      end
    end
    // Nothing may be accepted while reset is held, so no read can be launched.
    if (reset) begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
    end
`ifdef DMEM_ARB_RR_EN
    if (core_gnt) begin
      core_first_d = 1'b0;
    end else if (host_gnt) begin
      core_first_d = 1'b1;
    end
`endif
  end

  always_comb begin
    mem_en    = core_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (core_gnt && !core_we) begin
      rd_owner_d = OWN_CORE;
    end else if (host_gnt && !host_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  assign core_stall  = core_req & ~core_gnt;
  assign core_rvalid = (rd_owner_q == OWN_CORE);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_first_q <= 1'b1;
    end else begin
      core_first_q <= core_first_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, hand sequences and a
// randomized run against a rule-level model with a shadow memory.
module tb_dmem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_req, core_we, host_req, host_we, host_lock;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata;
  logic          core_gnt, host_gnt, core_stall, core_rvalid, host_rvalid;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];

  int checks = 0;
  int failures = 0;

  bit        m_burst;
  int        m_runs;
  bit        m_core_turn;
  int        m_rd_who;
  logic [7:0] m_rd_data;
  bit        last_cg, last_hg;

  typedef struct {
    bit          cr;
    bit          cw;
    logic [15:0] ca;
    bit          hr;
    bit          hw;
    logic [15:0] ha;
    logic [7:0]  hd;
    bit          hl;
    bit          ecg;
    bit          ehg;
  } vec_t;

  vec_t tbl [14];

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .core_gnt   (core_gnt),
    .host_gnt   (host_gnt),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on the edge ending the grant, read data next cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time_limit_expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst     = 1'b0;
    m_runs      = 0;
    m_core_turn = 1'b1;
    m_rd_who    = 0;
    m_rd_data   = 8'h00;
  endtask

  // Called at posedge+1; checks last cycle's read return, applies one cycle.
  task automatic drive_cycle(input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd,
                             input bit hr, input bit hw, input logic [15:0] ha, input logic [7:0] hd,
                             input bit hl);
    bit gc, gh, in_burst;
    chk("core_rvalid", core_rvalid, m_rd_who == 1);
    chk("host_rvalid", host_rvalid, m_rd_who == 2);
    chk("core_rdata", core_rdata, (m_rd_who == 1) ? m_rd_data : 8'h00);
    chk("host_rdata", host_rdata, (m_rd_who == 2) ? m_rd_data : 8'h00);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    gc = 1'b0; gh = 1'b0;
    in_burst = m_burst && hr && hl;
    if (in_burst) begin
      if (m_runs >= MAXB && cr) gc = 1'b1;
      else                      gh = 1'b1;
    end else if (cr && hr) begin
`ifdef DMEM_ARB_RR_EN
      gc = m_core_turn;
      gh = !m_core_turn;
`else
      gc = 1'b1;
`endif
    end else begin
      gc = cr;
      gh = hr;
    end
    #4;
    chk("core_gnt", core_gnt, gc);
    chk("host_gnt", host_gnt, gh);
    chk("core_stall", core_stall, cr && !gc);
    chk("mem_en", mem_en, gc || gh);
    if (gc || gh) begin
      chk("mem_we", mem_we, gc ? cw : hw);
      chk("mem_addr", mem_addr, gc ? ca : ha);
      if (gc ? cw : hw) chk("mem_wdata", mem_wdata, gc ? cd : hd);
    end
    last_cg = core_gnt;
    last_hg = host_gnt;
    m_rd_who = 0;
    if (gc) begin
      if (cw) shadow[ca] = cd;
      else begin m_rd_who = 1; m_rd_data = shadow[ca]; end
    end
    if (gh) begin
      if (hw) shadow[ha] = hd;
      else begin m_rd_who = 2; m_rd_data = shadow[ha]; end
    end
    if (in_burst) begin
      if (gc) m_runs = 0;
      else if (m_runs < MAXB) m_runs++;
    end else begin
      m_burst = gh && hl;
      m_runs  = (gh && hl) ? 1 : 0;
    end
    if (gc) m_core_turn = 1'b0;
    if (gh) m_core_turn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0);
  endtask

  // Assert reset with both ports requesting; everything must be quiet.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    core_req = 1'b1; host_req = 1'b1; core_we = 1'b0; host_we = 1'b0; host_lock = 1'b1;
    #1;
    chk({tag, "_rst_core_gnt"}, core_gnt, 0);
    chk({tag, "_rst_host_gnt"}, host_gnt, 0);
    chk({tag, "_rst_mem_en"}, mem_en, 0);
    chk({tag, "_rst_core_rvalid"}, core_rvalid, 0);
    chk({tag, "_rst_host_rvalid"}, host_rvalid, 0);
    chk({tag, "_rst_core_rdata"}, core_rdata, 0);
    chk({tag, "_rst_host_rdata"}, host_rdata, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_rst_hold_mem_en"}, mem_en, 0);
    reset = 1'b0;
    core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
  endtask

  initial begin
    int w;
    bit exp_c;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i * 7 + 3);
      shadow[i] = ram[i];
    end
    ram[16'h0010] = 8'h5A; shadow[16'h0010] = 8'h5A;
    ram[16'h0020] = 8'h3C; shadow[16'h0020] = 8'h3C;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    model_reset();
    @(posedge clk); #1;
    apply_reset("init");

    // Core read alone.
    drive_cycle(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0, 0);
    chk("single_core_gnt", last_cg, 1);
    chk("single_core_rvalid", core_rvalid, 1);
    chk("single_core_rdata", core_rdata, 8'h5A);
    chk("single_host_rvalid", host_rvalid, 0);
    idle_cycle();

    // Continuous conflict without lock.
    apply_reset("conflict");
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 0);
`ifdef DMEM_ARB_RR_EN
      exp_c = (i % 2) == 0;
`else
      exp_c = 1'b1;
`endif
      chk($sformatf("conflict%0d_core_gnt", i), last_cg, exp_c);
      chk($sformatf("conflict%0d_host_gnt", i), last_hg, !exp_c);
    end
    idle_cycle();

    // Locked host burst of 12 writes with core waiting.
    apply_reset("burst");
    for (int k = 0; k < 14; k++) begin
      w = (k <= 8) ? k : k - 1;
      tbl[k].cr  = (k >= 1) && (k <= 12);
      tbl[k].cw  = 1'b0;
      tbl[k].ca  = 16'h0100;
      tbl[k].hr  = (k <= 12);
      tbl[k].hw  = 1'b1;
      tbl[k].ha  = 16'(16'h0100 + w);
      tbl[k].hd  = 8'(8'hC0 + w);
      tbl[k].hl  = (k <= 12);
      tbl[k].ecg = (k == 8);
      tbl[k].ehg = (k <= 12) && (k != 8);
    end
    for (int k = 0; k < 14; k++) begin
      drive_cycle(tbl[k].cr, tbl[k].cw, tbl[k].ca, 8'h00,
                  tbl[k].hr, tbl[k].hw, tbl[k].ha, tbl[k].hd, tbl[k].hl);
      chk($sformatf("tbl%0d_core_gnt", k), last_cg, tbl[k].ecg);
      chk($sformatf("tbl%0d_host_gnt", k), last_hg, tbl[k].ehg);
    end

    // Back-to-back core read then host read.
    drive_cycle(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, 0);
    chk("b2b_core_rvalid", core_rvalid, 1);
    chk("b2b_core_rdata", core_rdata, 8'h5A);
    drive_cycle(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0);
    chk("b2b_host_rvalid", host_rvalid, 1);
    chk("b2b_host_rdata", host_rdata, 8'h3C);
    chk("b2b_core_rvalid_low", core_rvalid, 0);
    idle_cycle();

    // Reset while a core read is returning.
    drive_cycle(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, 0);
    apply_reset("midread");
    drive_cycle(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 0);
    chk("postrst_core_gnt", last_cg, 1);
    chk("postrst_host_gnt", last_hg, 0);
    idle_cycle();

    // Host drops lock mid-burst while core waits.
    apply_reset("drop");
    drive_cycle(0, 0, 16'h0, 8'h0, 1, 1, 16'h0200, 8'h11, 1);
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 0, 16'h0010, 8'h0, 1, 1, 16'(16'h0201 + i), 8'h22, 1);
    drive_cycle(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0204, 8'h33, 0);
    chk("drop_core_gnt", last_cg, 1);
    chk("drop_host_gnt", last_hg, 0);
    idle_cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset("rand");
      drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 7) != 0);
    end
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
